// File: rtl/adc_tap_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adc_tap_scan_ctrl_pkg
// Shared definitions for the ADC tap/bypass scan controller:
//   - DATA_W     : width of the signed channel samples
//   - state_e    : controller state encoding
//   - metric_w() : width of the |sample| accumulator for a given ACC_LOG2
// ---------------------------------------------------------------------------
package adc_tap_scan_ctrl_pkg;

    localparam int DATA_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_APPLY   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // 2^acc_log2 magnitudes of at most 2^(DATA_W-1) each fit in
    // DATA_W + acc_log2 bits, so the sum can never wrap.
    function automatic int metric_w(input int acc_log2);
        return DATA_W + acc_log2;
    endfunction

endpackage

// File: rtl/adc_tap_scan_ctrl_abs_accumulator.sv
// ---------------------------------------------------------------------------
// adc_tap_scan_ctrl_abs_accumulator
// Registered unsigned sum of |din_i|.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clears the sum on the next edge (has priority over en_i)
//   en_i       : adds |din_i| to the sum on the next edge
//   din_i      : signed DATA_W-bit sample
//   sum_o      : current accumulated sum (SUM_W bits, unsigned)
// ---------------------------------------------------------------------------
module adc_tap_scan_ctrl_abs_accumulator
    import adc_tap_scan_ctrl_pkg::*;
#(
    parameter int SUM_W = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] din_i,
    output logic        [SUM_W-1:0]  sum_o
);

    logic [DATA_W-1:0] din_u;
    logic [DATA_W-1:0] mag;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_d;

    // Two's-complement negate kept at DATA_W bits and read back as unsigned:
    // the most negative input (-4096) maps to 4096, which is exactly right.
    assign din_u = din_i;
    assign mag   = din_u[DATA_W-1] ? (~din_u + 1'b1) : din_u;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + SUM_W'(mag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/adc_tap_scan_ctrl.sv
// ---------------------------------------------------------------------------
// adc_tap_scan_ctrl
// Tap/bypass sequencer for one ADC input-alignment channel. In IDLE the host
// may write tap/bypass directly; a start pulse runs an auto-scan that steps
// the tap through every value, sums |din| over 2^ACC_LOG2 samples per tap
// after a settle delay, and applies the tap with the largest sum (ties keep
// the lower tap). An abort restores the configuration saved at start.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_i           : pulse, begins a scan when idle
//   abort_i           : pulse, cancels a scan in progress
//   manual_we_i       : manual write strobe (IDLE only)
//   manual_tap_i      : tap for manual write
//   manual_bypass_i   : bypass for manual write
//   din_i             : signed channel output samples
//   sr_tap_o          : registered tap to the channel
//   sr_bypass_o       : registered bypass to the channel
//   busy_o            : scan in progress
//   done_o            : one-cycle pulse when the best tap has been applied
//   best_tap_o        : tap found by the last completed scan
//   best_metric_o     : |din| sum measured at best_tap_o
// ---------------------------------------------------------------------------
module adc_tap_scan_ctrl
    import adc_tap_scan_ctrl_pkg::*;
#(
    parameter int         SETTLE_CYC = 8,
    parameter int         ACC_LOG2   = 6,
    parameter int         TAP_W      = 5,
    parameter logic [1:0] BYPASS_RST = 2'b01
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            manual_we_i,
    input  logic [TAP_W-1:0]                manual_tap_i,
    input  logic [1:0]                      manual_bypass_i,
    input  logic signed [DATA_W-1:0]        din_i,
    output logic [TAP_W-1:0]                sr_tap_o,
    output logic [1:0]                      sr_bypass_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [TAP_W-1:0]                best_tap_o,
    output logic [metric_w(ACC_LOG2)-1:0]   best_metric_o
);

    localparam int MET_W   = metric_w(ACC_LOG2);
    localparam int ACC_N   = 1 << ACC_LOG2;
    localparam int CNT_MAX = (SETTLE_CYC > ACC_N) ? SETTLE_CYC : ACC_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(ACC_N - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = {TAP_W{1'b1}};

    state_e             state_q,        state_d;
    logic [CNT_W-1:0]   cnt_q,          cnt_d;
    logic [TAP_W-1:0]   sr_tap_q,       sr_tap_d;
    logic [1:0]         sr_bypass_q,    sr_bypass_d;
    logic [TAP_W-1:0]   saved_tap_q,    saved_tap_d;
    logic [1:0]         saved_bypass_q, saved_bypass_d;
    logic [MET_W-1:0]   run_max_q,      run_max_d;
    logic [TAP_W-1:0]   run_tap_q,      run_tap_d;
    logic [TAP_W-1:0]   best_tap_q,     best_tap_d;
    logic [MET_W-1:0]   best_metric_q,  best_metric_d;

    logic               acc_clr;
    logic               acc_en;
    logic [MET_W-1:0]   acc_sum;
    logic               take_max;

    adc_tap_scan_ctrl_abs_accumulator #(
        .SUM_W (MET_W)
    ) u_abs_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .din_i (din_i),
        .sum_o (acc_sum)
    );

    // Tap 0 always seeds the running max; afterwards only a strictly larger
    // sum replaces it, so equal metrics keep the earlier (lower) tap.
    assign take_max = (acc_sum > run_max_q) || (sr_tap_q == '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sr_tap_d       = sr_tap_q;
        sr_bypass_d    = sr_bypass_q;
        saved_tap_d    = saved_tap_q;
        saved_bypass_d = saved_bypass_q;
        run_max_d      = run_max_q;
        run_tap_d      = run_tap_q;
        best_tap_d     = best_tap_q;
        best_metric_d  = best_metric_q;
        acc_clr        = 1'b0;
        acc_en         = 1'b0;

        if (abort_i && (state_q == ST_SETTLE || state_q == ST_ACCUM ||
                        state_q == ST_COMPARE || state_q == ST_APPLY)) begin
            sr_tap_d    = saved_tap_q;
            sr_bypass_d = saved_bypass_q;
            cnt_d       = '0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // start outranks a simultaneous manual write
                    if (start_i) begin
                        saved_tap_d    = sr_tap_q;
                        saved_bypass_d = sr_bypass_q;
                        sr_tap_d       = '0;
                        sr_bypass_d    = 2'b00;
                        run_max_d      = '0;
                        run_tap_d      = '0;
                        cnt_d          = '0;
                        state_d        = ST_SETTLE;
                    end else if (manual_we_i) begin
                        sr_tap_d    = manual_tap_i;
                        sr_bypass_d = manual_bypass_i;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_en = 1'b1;
                    if (cnt_q == ACCUM_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_COMPARE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (take_max) begin
                        run_max_d = acc_sum;
                        run_tap_d = sr_tap_q;
                    end
                    if (sr_tap_q == TAP_LAST) begin
                        // the last tap may itself be the new best
                        sr_tap_d = take_max ? sr_tap_q : run_tap_q;
                        state_d  = ST_APPLY;
                    end else begin
                        sr_tap_d = sr_tap_q + 1'b1;
                        state_d  = ST_SETTLE;
                    end
                    cnt_d = '0;
                end
                ST_APPLY: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d         = '0;
                        best_tap_d    = run_tap_q;
                        best_metric_d = run_max_q;
                        state_d       = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sr_tap_q       <= '0;
            sr_bypass_q    <= BYPASS_RST;
            saved_tap_q    <= '0;
            saved_bypass_q <= BYPASS_RST;
            run_max_q      <= '0;
            run_tap_q      <= '0;
            best_tap_q     <= '0;
            best_metric_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sr_tap_q       <= sr_tap_d;
            sr_bypass_q    <= sr_bypass_d;
            saved_tap_q    <= saved_tap_d;
            saved_bypass_q <= saved_bypass_d;
            run_max_q      <= run_max_d;
            run_tap_q      <= run_tap_d;
            best_tap_q     <= best_tap_d;
            best_metric_q  <= best_metric_d;
        end
    end

    assign sr_tap_o      = sr_tap_q;
    assign sr_bypass_o   = sr_bypass_q;
    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o        = (state_q == ST_DONE);
    assign best_tap_o    = best_tap_q;
    assign best_metric_o = best_metric_q;

endmodule

// File: tb/tb_adc_tap_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_tap_scan_ctrl
// Self-checking bench for adc_tap_scan_ctrl. A channel model drives din from
// the DUT's current tap; expected scan results are queued at start and
// compared when the done pulse appears.
// ---------------------------------------------------------------------------
module tb_adc_tap_scan_ctrl;
    import adc_tap_scan_ctrl_pkg::*;

    localparam int TAP_W    = 5;
    localparam int ACC_LOG2 = 6;
    localparam int MW       = DATA_W + ACC_LOG2;
    localparam int SETTLE   = 8;
    localparam int SCAN_LAT = 32 * (SETTLE + 64 + 1) + SETTLE + 1;  // 2345

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start_i = 1'b0;
    logic                     abort_i = 1'b0;
    logic                     manual_we_i = 1'b0;
    logic [TAP_W-1:0]         manual_tap_i = '0;
    logic [1:0]               manual_bypass_i = '0;
    logic signed [DATA_W-1:0] din_i = '0;
    logic [TAP_W-1:0]         sr_tap_o;
    logic [1:0]               sr_bypass_o;
    logic                     busy_o;
    logic                     done_o;
    logic [TAP_W-1:0]         best_tap_o;
    logic [MW-1:0]            best_metric_o;

    adc_tap_scan_ctrl #(
        .SETTLE_CYC (SETTLE),
        .ACC_LOG2   (ACC_LOG2),
        .TAP_W      (TAP_W),
        .BYPASS_RST (2'b01)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .manual_we_i     (manual_we_i),
        .manual_tap_i    (manual_tap_i),
        .manual_bypass_i (manual_bypass_i),
        .din_i           (din_i),
        .sr_tap_o        (sr_tap_o),
        .sr_bypass_o     (sr_bypass_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .best_tap_o      (best_tap_o),
        .best_metric_o   (best_metric_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               lat;
        logic [TAP_W-1:0] tap;
        logic [MW-1:0]    metric;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   pat_mode = 0;   // 0: peak at tap 13, 1: constant -4096
    logic phase    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Channel model: square wave whose amplitude depends on the applied tap.
    initial begin
        forever begin
            int mag;
            @(negedge clk);
            phase = ~phase;
            if (pat_mode == 1) begin
                din_i = -13'sd4096;
            end else begin
                mag   = (sr_tap_o == 5'd13) ? 1000 : 100;
                din_i = DATA_W'(phase ? mag : -mag);
            end
        end
    end

    always @(posedge clk) begin
        if (done_o === 1'b1) n_done <= n_done + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic manual_write(input logic [TAP_W-1:0] t, input logic [1:0] b);
        @(negedge clk);
        manual_tap_i    = t;
        manual_bypass_i = b;
        manual_we_i     = 1'b1;
        @(negedge clk);
        manual_we_i = 1'b0;
        $display("manual write: tap=%0d bypass=%0d -> sr_tap=%0d sr_bypass=%0d",
                 t, b, sr_tap_o, sr_bypass_o);
    endtask

    // Issue start, optionally inject start+manual_we while busy, and compare
    // the done-time outputs against the head of the scoreboard.
    task automatic run_scan(input int inject_at);
        exp_t e;
        int   cyc;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        check_eq("busy_after_start", 32'(busy_o), 32'd1);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < SCAN_LAT + 100) begin
            if (cyc == inject_at) begin
                start_i         = 1'b1;
                manual_we_i     = 1'b1;
                manual_tap_i    = 5'd3;
                manual_bypass_i = 2'b11;
            end
            @(posedge clk);
            #1;
            start_i     = 1'b0;
            manual_we_i = 1'b0;
            cyc++;
            if (cyc == inject_at + 1) begin
                check_eq("ignored_req_bypass", 32'(sr_bypass_o), 32'd0);
                check_eq("ignored_req_busy", 32'(busy_o), 32'd1);
            end
        end
        // done is visible after edge cyc and captured by the following edge
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("scan_latency", 32'(cyc + 1), 32'(e.lat));
            check_eq("best_tap", 32'(best_tap_o), 32'(e.tap));
            check_eq("best_metric", 32'(best_metric_o), 32'(e.metric));
            check_eq("applied_tap", 32'(sr_tap_o), 32'(e.tap));
            check_eq("applied_bypass", 32'(sr_bypass_o), 32'd0);
            check_eq("busy_in_done", 32'(busy_o), 32'd0);
        end
        $display("scan: done after %0d cycles best_tap=%0d best_metric=%0d",
                 cyc + 1, best_tap_o, best_metric_o);
        @(posedge clk);
        #1 check_eq("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    task automatic wait_tap(input logic [TAP_W-1:0] t, input string tag);
        int cyc;
        cyc = 0;
        while (sr_tap_o != t && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
        end
        check_eq(tag, 32'(sr_tap_o), 32'(t));
    endtask

    initial begin
        exp_t e;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_sr_tap", 32'(sr_tap_o), 32'd0);
        check_eq("rst_sr_bypass", 32'(sr_bypass_o), 32'd1);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_best_tap", 32'(best_tap_o), 32'd0);
        check_eq("rst_best_metric", 32'(best_metric_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Manual write in IDLE
        manual_write(5'd7, 2'b10);
        check_eq("manual_tap", 32'(sr_tap_o), 32'd7);
        check_eq("manual_bypass", 32'(sr_bypass_o), 32'd2);
        check_eq("manual_busy", 32'(busy_o), 32'd0);

        // Peak scan, with start+manual_we injected while busy
        pat_mode = 0;
        e.lat = SCAN_LAT; e.tap = 5'd13; e.metric = MW'(64000);
        sb_q.push_back(e);
        run_scan(500);

        // Constant most-negative input: all taps tie, tap 0 wins, no overflow
        pat_mode = 1;
        e.lat = SCAN_LAT; e.tap = 5'd0; e.metric = MW'(262144);
        sb_q.push_back(e);
        run_scan(-1);

        // Abort at tap 5 restores the pre-start configuration
        pat_mode = 0;
        manual_write(5'd9, 2'b01);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_tap(5'd5, "abort_reach_tap5");
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        check_eq("abort_sr_tap", 32'(sr_tap_o), 32'd9);
        check_eq("abort_sr_bypass", 32'(sr_bypass_o), 32'd1);
        check_eq("abort_busy", 32'(busy_o), 32'd0);
        check_eq("abort_best_tap", 32'(best_tap_o), 32'd0);
        check_eq("abort_best_metric", 32'(best_metric_o), 32'd262144);
        $display("abort: sr_tap=%0d sr_bypass=%0d busy=%0d", sr_tap_o, sr_bypass_o, busy_o);

        // start and manual_we together: scan starts, manual value discarded
        manual_write(5'd4, 2'b10);
        @(negedge clk);
        start_i         = 1'b1;
        manual_we_i     = 1'b1;
        manual_tap_i    = 5'd22;
        manual_bypass_i = 2'b11;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        manual_we_i = 1'b0;
        check_eq("same_cycle_tap", 32'(sr_tap_o), 32'd0);
        check_eq("same_cycle_bypass", 32'(sr_bypass_o), 32'd0);
        check_eq("same_cycle_busy", 32'(busy_o), 32'd1);
        repeat (3) @(posedge clk);
        #1 abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        check_eq("same_cycle_restore_tap", 32'(sr_tap_o), 32'd4);
        check_eq("same_cycle_restore_bypass", 32'(sr_bypass_o), 32'd2);
        $display("start+manual: restored sr_tap=%0d sr_bypass=%0d", sr_tap_o, sr_bypass_o);

        // Asynchronous reset in ACCUM at tap 20
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_tap(5'd20, "reset_reach_tap20");
        repeat (SETTLE + 10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_sr_tap", 32'(sr_tap_o), 32'd0);
        check_eq("midrst_sr_bypass", 32'(sr_bypass_o), 32'd1);
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_best_tap", 32'(best_tap_o), 32'd0);
        check_eq("midrst_best_metric", 32'(best_metric_o), 32'd0);
        $display("mid-scan reset: sr_tap=%0d sr_bypass=%0d busy=%0d", sr_tap_o, sr_bypass_o, busy_o);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full scan after reset release
        e.lat = SCAN_LAT; e.tap = 5'd13; e.metric = MW'(64000);
        sb_q.push_back(e);
        run_scan(-1);

        repeat (4) @(posedge clk);
        #1 check_eq("done_pulse_count", 32'(n_done), 32'd3);
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
